// File: rtl/count_to_4.sv
// Edge-triggered event counter: counts 0..MAX_COUNT and wraps, pulsing wrap on the return to 0.
// Define COUNT_TO_4_TRIG_SYNC_EN to pass trig through a 2-flop synchronizer before edge detection.
module count_to_4 #(
  parameter int unsigned MAX_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  output logic [2:0] count,
  output logic       at_max,
  output logic       wrap
);

  localparam logic [2:0] MaxVal = 3'(MAX_COUNT);

  logic       w_trig_s;
  logic       w_rise;
  logic [2:0] w_count_d;
  logic       w_at_max_d;
  logic       w_wrap_d;

  logic       r_trig_q;
  logic [2:0] r_count;
  logic       r_at_max;
  logic       r_wrap;

`ifdef COUNT_TO_4_TRIG_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= trig;
      r_sync2 <= r_sync1;
    end
  end

  assign w_trig_s = r_sync2;
`else
  assign w_trig_s = trig;
`endif

  assign w_rise = w_trig_s & ~r_trig_q;

  // Any value at or above MaxVal reloads 0, which also recovers from illegal states.
  always_comb begin
    w_count_d = r_count;
    w_wrap_d  = 1'b0;
    if (w_rise) begin
      if (r_count >= MaxVal) begin
        w_count_d = 3'd0;
        w_wrap_d  = (r_count == MaxVal);
      end else begin
        w_count_d = r_count + 3'd1;
      end
    end
    w_at_max_d = (w_count_d == MaxVal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig_q <= 1'b0;
      r_count  <= 3'd0;
      r_at_max <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_trig_q <= w_trig_s;
      r_count  <= w_count_d;
      r_at_max <= w_at_max_d;
      r_wrap   <= w_wrap_d;
    end
  end

  assign count  = r_count;
  assign at_max = r_at_max;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_count_to_4.sv
// Testbench for count_to_4: vector table, hand-written corner sequences and random stimulus
// checked against an event-counting reference model.
module tb_count_to_4;

  localparam int unsigned Max = 4;
`ifdef COUNT_TO_4_TRIG_SYNC_EN
  localparam int Delay = 2;
`else
  localparam int Delay = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [2:0] count;
  logic       at_max;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  count_to_4 #(.MAX_COUNT(Max)) dut (
    .clk    (clk),
    .rst    (rst),
    .trig   (trig),
    .count  (count),
    .at_max (at_max),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  // Reference model: trig seen Delay edges late; count is rises-since-reset modulo (Max+1).
  bit hist[$];
  int n_rise   = 0;
  bit prev_eff = 0;
  int exp_count = 0;
  bit exp_at_max = 0;
  bit exp_wrap = 0;

  task automatic model_edge(input logic r, input logic t);
    bit eff;
    bit rise;
    if (r) begin
      hist.delete();
      n_rise = 0;
      prev_eff = 0;
      exp_count = 0;
      exp_at_max = 0;
      exp_wrap = 0;
    end else begin
      hist.push_back(t);
      eff = (hist.size() > Delay) ? hist[hist.size() - 1 - Delay] : 1'b0;
      if (hist.size() > Delay + 1) void'(hist.pop_front());
      rise = eff && !prev_eff;
      prev_eff = eff;
      if (rise) n_rise++;
      exp_count = n_rise % (Max + 1);
      exp_wrap = rise && (exp_count == 0);
      exp_at_max = (exp_count == Max);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic t);
    @(negedge clk);
    rst = r;
    trig = t;
    @(posedge clk);
    model_edge(r, t);
    #1;
    check("model_count", int'(count), exp_count);
    check("model_at_max", int'(at_max), int'(exp_at_max));
    check("model_wrap", int'(wrap), int'(exp_wrap));
  endtask

  task automatic pulse();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
  endtask

  typedef struct {
    logic r;
    logic t;
    int   c;
    bit   a;
    bit   w;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic t, input int c, input bit a,
                              input bit w);
    vec_t v;
    v.r = r; v.t = t; v.c = c; v.a = a; v.w = w;
    vecs.push_back(v);
  endfunction

  initial begin
    int seq[6];
    seq = '{1, 2, 3, 4, 0, 1};

    // Reset for two cycles with trig low.
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    // Release reset with trig already high: one event.
    add(0, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 0);
    // Six pulses from reset: 1,2,3,4,0,1 with wrap on the 4->0 step only.
    add(1, 0, 0, 0, 0);
    for (int p = 0; p < 6; p++) begin
      add(0, 1, seq[p], seq[p] == 4, p == 4);
      add(0, 1, seq[p], seq[p] == 4, 0);
      for (int i = 0; i < 4; i++) add(0, 0, seq[p], seq[p] == 4, 0);
    end
    // Level-high trig for 10 cycles counts once.
    add(0, 1, 2, 0, 0);
    for (int i = 0; i < 9; i++) add(0, 1, 2, 0, 0);
    add(0, 0, 2, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].t);
`ifndef COUNT_TO_4_TRIG_SYNC_EN
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].c);
      check($sformatf("vec%0d_at_max", i), int'(at_max), int'(vecs[i].a));
      check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].w));
`endif
    end

    // Reset mid-sequence at count 3, coincident with a trig rise.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pulse();
    check("pre_rst_count3", int'(count), 3);
    step(1'b1, 1'b1);
    check("rst_priority_count", int'(count), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("after_rst_settled", int'(count), 0);
    pulse();
    check("resume_from_zero", int'(count), 1);

    // Trig high through reset release counts once.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("trig_high_at_release", int'(count), 1);

    // Level-high for 10 cycles, build-independent settled check.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("level_high_once", int'(count), 2);

    // Full wrap from reset, settled checks.
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pulse();
    check("settled_at_max_count", int'(count), 4);
    check("settled_at_max_flag", int'(at_max), 1);
    pulse();
    check("settled_wrapped", int'(count), 0);

    // Random trig with occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
